// File: rtl/demux_sel_if.sv
// Valid/ready bundle for the 1-to-2 steering unit: one producer channel in, two sink channels out.
// The producer/sink side drives through master; the steering block uses slave.
interface demux_sel_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_out_A;
    logic             valid_A;
    logic             ready_A;
    logic [WIDTH-1:0] data_out_B;
    logic             valid_B;
    logic             ready_B;
    logic [1:0]       count;

    modport master (
        output data_in, sel, in_valid, ready_A, ready_B,
        input  in_ready, data_out_A, valid_A, data_out_B, valid_B, count
    );

    modport slave (
        input  data_in, sel, in_valid, ready_A, ready_B,
        output in_ready, data_out_A, valid_A, data_out_B, valid_B, count
    );
endinterface

// File: rtl/demux_sel.sv
// Registered 1-to-2 steering unit: a 2-entry in-order FIFO of {sel, data} whose head is
// presented to sink A (sel=0) or sink B (sel=1); words leave strictly in acceptance order.
module demux_sel #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    demux_sel_if.slave   bus
);
    typedef struct packed {
        logic             sel;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    entry_t     head;
    logic       not_empty;
    logic       valid_a, valid_b;
    logic       pop, push, in_ready;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        not_empty = (count_q != 2'd0);
        valid_a   = not_empty & ~head.sel;
        valid_b   = not_empty &  head.sel;
        // Only the addressed sink's ready can retire the head.
        pop       = (valid_a & bus.ready_A) | (valid_b & bus.ready_B);
        in_ready  = rst_n & ((count_q != 2'd2) | pop);
        push      = bus.in_valid & in_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{sel: bus.sel, data: bus.data_in};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.valid_A    = valid_a;
    assign bus.valid_B    = valid_b;
    assign bus.data_out_A = head.data;
    assign bus.data_out_B = head.data;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_demux_sel.sv
// Bench for demux_sel: per-cycle vector table, hand-written reset and random push/pop
// sequences, and a scoreboard checking order and destination of every delivered word.
module tb_demux_sel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_sel_if #(.WIDTH(32)) bus ();
    demux_sel #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        sel;
        logic [31:0] data;
    } word_t;
    word_t sb[$];

    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] d;
        logic        ra;
        logic        rb;
        logic [1:0]  e_cnt;
        logic        e_ir;
        logic        e_va;
        logic        e_vb;
        logic [31:0] e_d;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic sel, input logic [31:0] d,
                                input logic ra, input logic rb, input logic [1:0] e_cnt,
                                input logic e_ir, input logic e_va, input logic e_vb,
                                input logic [31:0] e_d);
        vec_t v;
        v.iv = iv; v.sel = sel; v.d = d; v.ra = ra; v.rb = rb;
        v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_va = e_va; v.e_vb = e_vb; v.e_d = e_d;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic sel, input logic [31:0] d,
                         input logic ra, input logic rb);
        bus.in_valid = iv;
        bus.sel      = sel;
        bus.data_in  = d;
        bus.ready_A  = ra;
        bus.ready_B  = rb;
    endtask

    // Scoreboard: record accepted words, check every delivered word at the negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.valid_A && bus.valid_B)
                chk("both_valid", 32'd1, 32'd0);
            if ((bus.valid_A && bus.ready_A) || (bus.valid_B && bus.ready_B)) begin
                if (sb.size() == 0) begin
                    chk("pop_empty_sb", 32'd1, 32'd0);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    chk("sb_dest", {31'd0, bus.valid_B}, {31'd0, w.sel});
                    chk("sb_data", bus.valid_B ? bus.data_out_B : bus.data_out_A, w.data);
                end
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back('{sel: bus.sel, data: bus.data_in});
        end
    end

    initial begin
        // basic steering
        tbl[0]  = mk(1, 0, 32'hDEADBEEF, 1, 1, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'h12345678, 1, 1, 1, 1, 1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 0,            1, 1, 1, 1, 0, 1, 32'h12345678);
        tbl[3]  = mk(0, 0, 0,            1, 1, 0, 1, 0, 0, 0);
        // full and back-pressure
        tbl[4]  = mk(1, 0, 32'hA1, 0, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(1, 0, 32'hA2, 0, 1, 1, 1, 1, 0, 32'hA1);
        tbl[6]  = mk(1, 0, 32'hA3, 0, 1, 2, 0, 1, 0, 32'hA1);
        tbl[7]  = mk(1, 0, 32'hA3, 1, 1, 2, 1, 1, 0, 32'hA1);
        tbl[8]  = mk(0, 0, 0,      1, 1, 2, 1, 1, 0, 32'hA2);
        tbl[9]  = mk(0, 0, 0,      1, 1, 1, 1, 1, 0, 32'hA3);
        tbl[10] = mk(0, 0, 0,      1, 1, 0, 1, 0, 0, 0);
        // head-of-line blocking
        tbl[11] = mk(1, 0, 32'h1, 0, 1, 0, 1, 0, 0, 0);
        tbl[12] = mk(1, 1, 32'h2, 0, 1, 1, 1, 1, 0, 32'h1);
        tbl[13] = mk(0, 0, 0,     0, 1, 2, 0, 1, 0, 32'h1);
        tbl[14] = mk(0, 0, 0,     1, 1, 2, 1, 1, 0, 32'h1);
        tbl[15] = mk(0, 0, 0,     0, 1, 1, 1, 0, 1, 32'h2);
        tbl[16] = mk(0, 0, 0,     1, 1, 0, 1, 0, 0, 0);
        // non-selected ready ignored
        tbl[17] = mk(1, 1, 32'hCAFEF00D, 1, 0, 0, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 0,            1, 0, 1, 1, 0, 1, 32'hCAFEF00D);
        tbl[19] = mk(0, 0, 0,            1, 0, 1, 1, 0, 1, 32'hCAFEF00D);
        tbl[20] = mk(0, 0, 0,            0, 1, 1, 1, 0, 1, 32'hCAFEF00D);
        tbl[21] = mk(0, 0, 0,            1, 1, 0, 1, 0, 0, 0);

        drive(0, 0, 0, 0, 0);
        #2;
        chk("rst_count",    {30'd0, bus.count},    32'd0);
        chk("rst_valid_A",  {31'd0, bus.valid_A},  32'd0);
        chk("rst_valid_B",  {31'd0, bus.valid_B},  32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ra, tbl[i].rb);
            @(negedge clk);
            chk($sformatf("v%0d_count", i),    {30'd0, bus.count},    {30'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("v%0d_valid_A", i),  {31'd0, bus.valid_A},  {31'd0, tbl[i].e_va});
            chk($sformatf("v%0d_valid_B", i),  {31'd0, bus.valid_B},  {31'd0, tbl[i].e_vb});
            if (tbl[i].e_va) chk($sformatf("v%0d_data_A", i), bus.data_out_A, tbl[i].e_d);
            if (tbl[i].e_vb) chk($sformatf("v%0d_data_B", i), bus.data_out_B, tbl[i].e_d);
        end

        // Random simultaneous push/pop at count=1: head's sink always ready, other random.
        @(posedge clk); #1;
        drive(1, 1'($urandom), $urandom, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            logic s, r;
            s = 1'($urandom);
            r = 1'($urandom);
            if (sb.size() == 0) begin
                chk("rnd_sb_empty", 32'd1, 32'd0);
                break;
            end
            if (sb[0].sel) drive(1, s, $urandom, r, 1);
            else           drive(1, s, $urandom, 1, r);
            @(negedge clk);
            chk("rnd_count", {30'd0, bus.count}, 32'd1);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_count", {30'd0, bus.count}, 32'd0);
        chk("drain_sb", sb.size(), 32'd0);

        // Reset mid-stream with two words queued.
        drive(1, 0, 32'h55, 0, 0);
        @(posedge clk); #1;
        drive(1, 1, 32'h66, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_count", {30'd0, bus.count}, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count",   {30'd0, bus.count},   32'd0);
        chk("mid_rst_valid_A", {31'd0, bus.valid_A}, 32'd0);
        chk("mid_rst_valid_B", {31'd0, bus.valid_B}, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("post_rst_count",    {30'd0, bus.count},    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
